// File: rtl/motor_atributos_if.sv
// Action/status bundle for motor_atributos.
// The master drives actions and revive; the slave (the engine) returns channel state.
interface motor_atributos_if #(
   parameter int N_ATTR = 3,
   parameter int WIDTH  = 8
);
   localparam int IDX_W = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;

   logic                      acao_valida;
   logic [IDX_W-1:0]          acao_idx;
   logic [WIDTH-1:0]          acao_ganho;
   logic                      reviver;
   logic [N_ATTR*WIDTH-1:0]   atributos;
   logic [N_ATTR-1:0]         alerta;
   logic                      tick;
   logic                      morreu;

   modport master (
      output acao_valida, acao_idx, acao_ganho, reviver,
      input  atributos, alerta, tick, morreu
   );

   modport slave (
      input  acao_valida, acao_idx, acao_ganho, reviver,
      output atributos, alerta, tick, morreu
   );
endinterface

// File: rtl/motor_atributos.sv
// Attribute engine: N channels that decay on a divided tick, gain from actions,
// saturate, and drive a VIVO/MORTO life-cycle FSM.
module motor_atributos #(
   parameter int                  N_ATTR   = 3,
   parameter int                  WIDTH    = 8,
   parameter int                  INIT_VAL = 128,
   parameter int                  TICK_DIV = 50000000,
   parameter logic [8*N_ATTR-1:0] DECAY    = {8'd3, 8'd2, 8'd1},
   parameter int                  LIMIAR   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   motor_atributos_if.slave   bus
);
   localparam int IDX_W = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
   localparam int CW    = $clog2(TICK_DIV);
   localparam logic [WIDTH-1:0] INIT_SAT =
      (longint'(INIT_VAL) >= (longint'(1) << WIDTH)) ? {WIDTH{1'b1}} : WIDTH'(INIT_VAL);
   localparam logic INIT_ALERT = (int'(INIT_SAT) < LIMIAR);

   typedef enum logic {VIVO, MORTO} state_t;

   state_t          state_reg;
   logic            morreu_reg;
   logic [CW-1:0]   tick_cnt_reg;
   logic            tick;
   logic [N_ATTR-1:0] zero_vec;
   logic            any_zero;

   assign tick     = (tick_cnt_reg == CW'(TICK_DIV - 1));
   assign any_zero = |zero_vec;

   // Free-running tick divider; keeps counting while dead.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_reg <= '0;
      end else if (tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= VIVO;
         morreu_reg <= 1'b0;
      end else begin
         case (state_reg)
            VIVO: begin
               if (any_zero) begin
                  state_reg  <= MORTO;
                  morreu_reg <= 1'b1;
               end
            end
            MORTO: begin
               if (bus.reviver) begin
                  state_reg  <= VIVO;
                  morreu_reg <= 1'b0;
               end
            end
            default: begin
               state_reg  <= VIVO;
               morreu_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tick   = tick;
   assign bus.morreu = morreu_reg;

   generate
      for (genvar gi = 0; gi < N_ATTR; gi++) begin : g_ch
         localparam logic [7:0] D_LAST = DECAY[8*gi +: 8] - 8'd1;

         logic [WIDTH-1:0]        chan_reg, chan_next;
         logic [7:0]              dcnt_reg, dcnt_next;
         logic                    alerta_reg;
         logic [WIDTH-1:0]        gain_sel;
         logic                    dec;
         logic signed [WIDTH+1:0] sum;

         assign zero_vec[gi] = (chan_reg == '0);
         assign gain_sel = (bus.acao_valida && bus.acao_idx == IDX_W'(gi)) ? bus.acao_ganho : '0;

         always_comb begin
            chan_next = chan_reg;
            dcnt_next = dcnt_reg;
            dec       = 1'b0;
            sum       = '0;
            if (state_reg == MORTO) begin
               dcnt_next = '0;
               if (bus.reviver) begin
                  chan_next = INIT_SAT;
               end
            end else if (any_zero) begin
               // Dying edge: discard this cycle's action and decay.
               dcnt_next = '0;
            end else begin
               if (tick) begin
                  if (dcnt_reg == D_LAST) begin
                     dcnt_next = '0;
                     dec       = 1'b1;
                  end else begin
                     dcnt_next = dcnt_reg + 8'd1;
                  end
               end
               sum = $signed({2'b00, chan_reg}) + $signed({2'b00, gain_sel})
                   - $signed({{(WIDTH+1){1'b0}}, dec});
               if (sum < 0) begin
                  chan_next = '0;
               end else if (sum > $signed({2'b00, {WIDTH{1'b1}}})) begin
                  chan_next = {WIDTH{1'b1}};
               end else begin
                  chan_next = sum[WIDTH-1:0];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               chan_reg   <= INIT_SAT;
               dcnt_reg   <= '0;
               alerta_reg <= INIT_ALERT;
            end else begin
               chan_reg   <= chan_next;
               dcnt_reg   <= dcnt_next;
               alerta_reg <= (int'(chan_next) < LIMIAR);
            end
         end

         assign bus.atributos[WIDTH*gi +: WIDTH] = chan_reg;
         assign bus.alerta[gi] = alerta_reg;
      end
   endgenerate
endmodule
